// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, the
// legal stack-window bounds, and the address-window check. The CPU address
// decoder imports the same constants, so both see identical limits.
// ---------------------------------------------------------------------------
package dmem_pkg;

    // Highest legal byte address (word aligned) and number of legal words.
    localparam logic [31:0] MEM_TOP   = 32'h7fff_fffc;
    localparam int unsigned MEM_WORDS = 257;

    // Lowest legal byte address: MEM_TOP - 4*(MEM_WORDS-1).
    localparam logic [31:0] MEM_LOW   = MEM_TOP - 32'(4 * (MEM_WORDS - 1));

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Requester identifiers.
    localparam logic REQ_CPU   = 1'b0;
    localparam logic REQ_DEBUG = 1'b1;

    // True when an address is misaligned or falls outside [low, top].
    function automatic logic addr_out_of_window(
        input logic [31:0] addr,
        input logic [31:0] top,
        input logic [31:0] low
    );
        logic misaligned;
        misaligned = (addr[1:0] != 2'b00);
        return misaligned || (addr > top) || (addr < low);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant with its last-grant pointer.
//
// Ports
//   clock      in   clock; pointer updates on the rising edge
//   reset      in   asynchronous active-high reset
//   enable     in   arbitration allowed this cycle (sequencer idle)
//   valid0/1   in   request pending from requester 0 / 1
//   accept     in   the current grant is being taken at this edge
//   grant      out  id of the winning requester (meaningful with grant_any)
//   grant_any  out  some requester is being granted this cycle
// ---------------------------------------------------------------------------
module rr_arb2
    import dmem_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant,
    output logic grant_any
);

    // Id of the requester granted most recently. Resets to requester 1 so that
    // requester 0 wins the first tie.
    logic last;

    always_comb begin
        grant     = REQ_CPU;
        grant_any = 1'b0;
        if (enable) begin
            grant_any = valid0 | valid1;
            if (valid0 && valid1) begin
                grant = ~last;
            end else if (valid1) begin
                grant = REQ_DEBUG;
            end else begin
                grant = REQ_CPU;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last <= REQ_DEBUG;
        end else if (accept) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU load/store path
// (requester 0) and the debug/loader port (requester 1). Requests are
// granted round-robin, range-checked against the stack window, executed in
// one memory cycle, and completed with a one-cycle rvalid pulse.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | arbitrating; ready asserted toward the granted requester
//   ACCESS | memory strobes driven from the latched request (unless error)
//   DONE   | rvalid/rdata/err presented to the requester that was served
//
// Ports
//   clock, reset                clock and asynchronous active-high reset
//   reqN_valid/write/addr/wdata request N (N = 0, 1); hold until ready
//   reqN_ready                  request N accepted at this edge if valid
//   reqN_rvalid/rdata/err       one-cycle completion to requester N
//   mem_read/write/addr/wdata   to dataMem (write commits on falling edge)
//   mem_rdata                   combinational read data from dataMem
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [31:0] MEM_TOP   = dmem_pkg::MEM_TOP,
    parameter int unsigned MEM_WORDS = dmem_pkg::MEM_WORDS
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_rvalid,
    output logic [31:0] req0_rdata,
    output logic        req0_err,

    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_rvalid,
    output logic [31:0] req1_rdata,
    output logic        req1_err,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] WIN_LOW = MEM_TOP - 32'(4 * (MEM_WORDS - 1));

    state_t      state;
    state_t      state_nxt;

    logic        grant;
    logic        grant_any;
    logic        accept;
    logic        in_idle;

    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_id;

    logic        addr_err;
    logic        err_q;
    logic [31:0] rdata_q;

    assign in_idle = (state == IDLE);
    assign accept  = in_idle && grant_any;

    rr_arb2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .enable    (in_idle),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_any (grant_any)
    );

    // The check runs on the latched address so the requester may change its
    // inputs as soon as it has been accepted.
    assign addr_err = addr_out_of_window(lat_addr, MEM_TOP, WIN_LOW);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, loaded from the granted requester on acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_id    <= REQ_CPU;
        end else if (accept) begin
            lat_id <= grant;
            if (grant == REQ_DEBUG) begin
                lat_write <= req1_write;
                lat_addr  <= req1_addr;
                lat_wdata <= req1_wdata;
            end else begin
                lat_write <= req0_write;
                lat_addr  <= req0_addr;
                lat_wdata <= req0_wdata;
            end
        end
    end

    // Response capture at the end of the ACCESS cycle. Stores and faulting
    // accesses return zero data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (state == ACCESS) begin
            err_q   <= addr_err;
            rdata_q <= (!lat_write && !addr_err) ? mem_rdata : '0;
        end
    end

    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        req0_rvalid = 1'b0;
        req1_rvalid = 1'b0;
        req0_rdata  = '0;
        req1_rdata  = '0;
        req0_err    = 1'b0;
        req1_err    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        // Ready is held low while reset is asserted even though the state
        // register already reads IDLE.
        if (in_idle && grant_any && !reset) begin
            req0_ready = (grant == REQ_CPU);
            req1_ready = (grant == REQ_DEBUG);
        end

        if (state == ACCESS) begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            if (!addr_err) begin
                mem_read  = !lat_write;
                mem_write = lat_write;
            end
        end

        if (state == DONE) begin
            if (lat_id == REQ_DEBUG) begin
                req1_rvalid = 1'b1;
                req1_rdata  = rdata_q;
                req1_err    = err_q;
            end else begin
                req0_rvalid = 1'b1;
                req0_rdata  = rdata_q;
                req0_err    = err_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Scoreboarded bench for dmem_arbiter. A behavioural dataMem model answers
// the memory pins; a shadow memory predicts load data. Every accepted request
// pushes its expected response, which is popped and compared on rvalid.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam logic [31:0] TOP = 32'h7fff_fffc;
    localparam logic [31:0] LOW = 32'h7fff_fbfc;

    logic        clock = 1'b0;
    logic        reset;

    logic        req0_valid, req0_write, req0_ready, req0_rvalid, req0_err;
    logic [31:0] req0_addr, req0_wdata, req0_rdata;
    logic        req1_valid, req1_write, req1_ready, req1_rvalid, req1_err;
    logic [31:0] req1_addr, req1_wdata, req1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_write  (req0_write),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_ready  (req0_ready),
        .req0_rvalid (req0_rvalid),
        .req0_rdata  (req0_rdata),
        .req0_err    (req0_err),
        .req1_valid  (req1_valid),
        .req1_write  (req1_write),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_ready  (req1_ready),
        .req1_rvalid (req1_rvalid),
        .req1_rdata  (req1_rdata),
        .req1_err    (req1_err),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        id;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic        grant_log[$];
    logic [31:0] mem    [0:256];
    logic [31:0] shadow [0:256];
    bit          mem_init = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int nwrites  = 0;
    int n_rv0    = 0;
    int n_rv1    = 0;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > TOP) || (a < LOW);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - LOW) >> 2);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return {16'hA5C3, 16'(i)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic predict(input logic id, input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
        exp_t e;
        e.id    = id;
        e.write = wr;
        e.addr  = a;
        e.wdata = d;
        e.err   = bad_addr(a);
        e.rdata = 32'h0;
        if (!e.err && !wr) e.rdata = shadow[widx(a)];
        e.cyc   = cyc + 2;
        exp_q.push_back(e);
        grant_log.push_back(id);
    endtask

    always_comb begin
        mem_rdata = 32'h0;
        if (!bad_addr(mem_addr)) mem_rdata = mem[widx(mem_addr)];
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge reset) exp_q.delete();

    // dataMem model (falling-edge write), acceptance predictor, response checker.
    always @(negedge clock) begin : mon
        exp_t        e;
        logic        got_err;
        logic [31:0] got_rdata;
        if (!mem_init) begin
            for (int i = 0; i < 257; i++) begin
                mem[i]    = init_word(i);
                shadow[i] = init_word(i);
            end
            mem_init = 1'b1;
        end
        if (mem_write) begin
            nwrites++;
            if (!bad_addr(mem_addr)) mem[widx(mem_addr)] = mem_wdata;
        end
        if (!reset) begin
            if (req0_valid && req0_ready)
                predict(1'b0, req0_write, req0_addr, req0_wdata);
            else if (req1_valid && req1_ready)
                predict(1'b1, req1_write, req1_addr, req1_wdata);

            if (req0_rvalid) n_rv0++;
            if (req1_rvalid) n_rv1++;
            if (req0_rvalid || req1_rvalid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rvalid", {30'b0, req1_rvalid, req0_rvalid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    got_err   = e.id ? req1_err   : req0_err;
                    got_rdata = e.id ? req1_rdata : req0_rdata;
                    check("rv_pulse", {30'b0, req1_rvalid, req0_rvalid}, e.id ? 32'd2 : 32'd1);
                    check("rv_err",   {31'b0, got_err}, {31'b0, e.err});
                    check("rv_rdata", got_rdata, e.rdata);
                    check("rv_cycle", cyc, e.cyc);
                    if (!e.err && e.write) shadow[widx(e.addr)] = e.wdata;
                end
            end
        end
    end

    task automatic set_req(input logic id, input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
        if (id) begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = d;
        end
    endtask

    // Drive a request and wait for its acceptance; returns one time unit after
    // the accepting edge. With hold set, valid stays high for a follow-on.
    task automatic issue(input logic id, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
        bit ok;
        ok = 1'b0;
        set_req(id, wr, a, d);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if ((id && req1_ready) || (!id && req0_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        check(id ? "accept1" : "accept0", {31'b0, ok}, 32'd1);
        @(posedge clock);
        #1;
        if (!hold) begin
            if (id) req1_valid = 1'b0;
            else    req0_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0) break;
        end
        check("drain", exp_q.size(), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    int          w0;
    int          rv_before;
    bit          got_rdy;

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;

        // Reset values, with both requesters asserting valid.
        #12;
        check("rst_ready0",  {31'b0, req0_ready},  32'd0);
        check("rst_ready1",  {31'b0, req1_ready},  32'd0);
        check("rst_rvalid0", {31'b0, req0_rvalid}, 32'd0);
        check("rst_rvalid1", {31'b0, req1_rvalid}, 32'd0);
        check("rst_err0",    {31'b0, req0_err},    32'd0);
        check("rst_err1",    {31'b0, req1_err},    32'd0);
        check("rst_rdata0",  req0_rdata, 32'd0);
        check("rst_rdata1",  req1_rdata, 32'd0);
        check("rst_mem_read",  {31'b0, mem_read},  32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_mem_addr",  mem_addr,  32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;

        // Store then load at the top of the window.
        w0 = nwrites;
        issue(1'b0, 1'b1, 32'h7fff_fffc, 32'hDEAD_BEEF, 1'b0);
        wait_drain();
        check("t1_write_cycles", nwrites - w0, 32'd1);
        check("t1_mem_word", mem[widx(32'h7fff_fffc)], 32'hDEAD_BEEF);
        issue(1'b0, 1'b0, 32'h7fff_fffc, 32'h0, 1'b0);
        wait_drain();

        // Continuous tie after reset: grants alternate 0, 1, 0, 1.
        do_reset();
        grant_log.delete();
        n_rv0 = 0;
        n_rv1 = 0;
        fork
            begin
                issue(1'b0, 1'b0, 32'h7fff_fbfc, 32'h0, 1'b1);
                issue(1'b0, 1'b0, 32'h7fff_fbfc, 32'h0, 1'b0);
            end
            begin
                issue(1'b1, 1'b0, 32'h7fff_fc00, 32'h0, 1'b1);
                issue(1'b1, 1'b0, 32'h7fff_fc00, 32'h0, 1'b0);
            end
        join
        wait_drain();
        check("t2_grant_count", grant_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check("t2_grant_order", {31'b0, grant_log[i]}, i % 2);
        end
        check("t2_rvalid0_count", n_rv0, 32'd2);
        check("t2_rvalid1_count", n_rv1, 32'd2);

        // Window bounds; faulting stores must not touch memory.
        issue(1'b0, 1'b0, 32'h7fff_fbfc, 32'h0, 1'b0);
        wait_drain();
        w0 = nwrites;
        issue(1'b1, 1'b1, 32'h7fff_fbf8, 32'hA5A5_A5A5, 1'b0);
        wait_drain();
        issue(1'b0, 1'b1, 32'h8000_0000, 32'h5A5A_5A5A, 1'b0);
        wait_drain();
        issue(1'b1, 1'b1, 32'h7fff_fffe, 32'h0BAD_F00D, 1'b0);
        wait_drain();
        check("t3_err_no_write", nwrites - w0, 32'd0);
        issue(1'b0, 1'b0, 32'h7fff_fffc, 32'h0, 1'b0);
        wait_drain();
        issue(1'b1, 1'b1, 32'h7fff_fbfc, 32'h1234_5678, 1'b0);
        wait_drain();
        issue(1'b0, 1'b0, 32'h7fff_fbfc, 32'h0, 1'b0);
        wait_drain();

        // req1 waits, with its store data changing, while req0 is served.
        issue(1'b0, 1'b1, 32'h7fff_fc04, 32'hCAFE_F00D, 1'b0);
        set_req(1'b1, 1'b1, 32'h7fff_fc08, 32'h1111_2222);
        @(negedge clock);
        check("t4_ready1_access", {31'b0, req1_ready}, 32'd0);
        @(posedge clock);
        #1 req1_wdata = 32'h3333_4444;
        @(negedge clock);
        check("t4_ready1_done", {31'b0, req1_ready}, 32'd0);
        got_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (req1_ready) begin
                got_rdy = 1'b1;
                break;
            end
        end
        check("t4_accept1", {31'b0, got_rdy}, 32'd1);
        @(posedge clock);
        #1 req1_valid = 1'b0;
        wait_drain();
        check("t4_latched_wdata", mem[widx(32'h7fff_fc08)], 32'h3333_4444);
        issue(1'b0, 1'b0, 32'h7fff_fc08, 32'h0, 1'b0);
        wait_drain();

        // Reset between the accepting edge and the store's falling edge.
        rv_before = n_rv0 + n_rv1;
        issue(1'b0, 1'b1, 32'h7fff_fff8, 32'hBAD0_BAD0, 1'b0);
        reset = 1'b1;
        #1;
        check("t5_mem_write", {31'b0, mem_write}, 32'd0);
        check("t5_mem_read",  {31'b0, mem_read},  32'd0);
        check("t5_mem_addr",  mem_addr, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("t5_no_rvalid", n_rv0 + n_rv1 - rv_before, 32'd0);
        check("t5_mem_kept", mem[widx(32'h7fff_fff8)], init_word(widx(32'h7fff_fff8)));
        grant_log.delete();
        fork
            issue(1'b0, 1'b0, 32'h7fff_fff8, 32'h0, 1'b0);
            issue(1'b1, 1'b0, 32'h7fff_fbfc, 32'h0, 1'b0);
        join
        wait_drain();
        check("t5_tie_count", grant_log.size(), 32'd2);
        if (grant_log.size() > 0) check("t5_tie_first", {31'b0, grant_log[0]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-port data memory (`dataMem`). It shares the memory between the CPU load/store path (requester 0) and a debug/loader port (requester 1). The block grants requesters round-robin and range-checks every access against the stack-region window. It drives the memory's `memRead`/`memWrite`/`address`/`writeData` pins and returns read data through a valid/ready handshake.

## Interface
- `MEM_TOP` — default 32'h7ffffffc — highest legal byte address (word-aligned).
- `MEM_WORDS` — default 257 — number of legal words; lowest legal byte address is `MEM_TOP - 4*(MEM_WORDS-1)` = 32'h7ffffbfc.
- `clock` in 1 — single clock. Decisions on rising edge; memory writes on the falling edge inside the ACCESS cycle.
- `reset` in 1 — asynchronous, active-high.
- `reqN_valid` in 1 — request N (N = 0, 1) pending.
- `reqN_write` in 1 — 1 = store, 0 = load.
- `reqN_addr` in 32 — byte address.
- `reqN_wdata` in 32 — store data.
- `reqN_ready` out 1 — request N accepted at this rising edge if `valid` is also high.
- `reqN_rvalid` out 1 — one-cycle completion pulse to requester N.
- `reqN_rdata` out 32 — load data; valid while `rvalid` is high.
- `reqN_err` out 1 — qualifies `rvalid`: misaligned or out-of-window address.
- `mem_read` out 1 — to `dataMem.memRead`.
- `mem_write` out 1 — to `dataMem.memWrite`.
- `mem_addr` out 32 — to `dataMem.address`.
- `mem_wdata` out 32 — to `dataMem.writeData`.
- `mem_rdata` in 32 — from `dataMem.readData` (combinational).

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE → ACCESS:** taken on the edge where the granted requester is valid. At that edge, latch `write`, `addr`, `wdata`, and the granted id.
- **ACCESS → DONE:** unconditional. At this edge, capture `mem_rdata` (loads) and the error flag.
- **DONE → IDLE:** unconditional.
- **Grant:**
  - Computed combinationally in IDLE only.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted most recently wins.
  - The last-grant pointer updates only on acceptance; it resets to "1 was last", so requester 0 wins the first tie.
- **`reqN_ready`:** equals `state==IDLE && grant==N`. It is low in ACCESS and DONE.
- **Requester rule:** hold `valid`, `write`, `addr`, and `wdata` stable until accepted.
- **Address check (on latched address):**
  - Error if `addr[1:0] != 0`.
  - Error if `addr > MEM_TOP`.
  - Error if `addr < MEM_TOP - 4*(MEM_WORDS-1)`.
- **ACCESS, no error:** `mem_read = !write`, `mem_write = write`, `mem_addr`/`mem_wdata` = latched values.
- **ACCESS, error:** both strobes stay 0 and memory is untouched.
- **DONE:**
  - `reqN_rvalid` = 1 for the latched id only.
  - `reqN_rdata` = captured data for loads; 0 for stores or errors.
  - `reqN_err` = latched error flag.
- **Outside ACCESS:** `mem_read = mem_write = 0`, `mem_addr = mem_wdata = 0`.

## Timing
- Accept at edge E0. Memory strobes are high for the full cycle E0–E1; the store commits at the negedge in that cycle. Load data is sampled at E1. `rvalid` is high for cycle E1–E2. The next acceptance is possible at E3.
- Throughput is one access per 3 cycles. Back-to-back ties alternate 0, 1, 0, 1.
- A requester whose valid drops before acceptance is simply not granted.
- **Reset values (asserted asynchronously):**
  - state = IDLE, last-grant = 1.
  - All `ready`, `rvalid`, `err`, `mem_read`, `mem_write` = 0.
  - All data and address outputs = 0.
- **Reset during ACCESS:** strobes drop immediately. A store whose negedge falls after reset assertion is suppressed. The aborted transaction is never reported with `rvalid`.
- On the first edge after reset release, ready follows normal IDLE grant rules.

## Structure
- **Shared package `dmem_pkg`:**
  - State encoding constants: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2.
  - `MEM_TOP`, the lowest-address constant, and `MEM_WORDS`, so the CPU decoder and the bench use identical bounds.
- **Sub-module `rr_arb2`:** combinational grant from two valids plus the last-grant pointer, with the pointer register. It is enabled by an accept strobe.
- **Top level:** the FSM, latches, range check, and response muxing stay in `dmem_arbiter`.

## Test plan
1. **Single store then load:** req0 store 32'hDEADBEEF to 32'h7ffffffc, then load from the same address. Required: `mem_write` high exactly one cycle; load `rdata` = 32'hDEADBEEF, `err` = 0, `rvalid` two edges after acceptance.
2. **Tie arbitration:** both valid continuously after reset, loads to 32'h7ffffbfc / 32'h7ffffc00. Required: grants in order 0, 1, 0, 1; each requester gets exactly one `rvalid` per grant.
3. **Window bounds:**
   - 32'h7ffffbfc is legal.
   - 32'h7ffffbf8 gives `err` = 1.
   - 32'h80000000 gives `err` = 1.
   - 32'h7ffffffe (misaligned) gives `err` = 1.
   - Erroring stores leave memory unchanged (checked by readback).
4. **Handshake stability:** req1 valid held with changing wdata while req0 is busy. Required: req1 `ready` stays low until IDLE; the value latched is the one present at acceptance.
5. **Reset mid-ACCESS:** assert reset between the rising edge and the negedge of a store cycle. Required: strobes low immediately, memory word unchanged, no `rvalid`, state IDLE, req0 wins the next tie.
